// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory responder: loader states,
// response-control codes and the default NOP word.
package imem_pkg;

    localparam logic [15:0] DEF_NOP_INST = 16'h0000;

    typedef enum logic [2:0] {
        L_IDLE,
        L_AHI,
        L_ALO,
        L_DHI,
        L_DLO
    } ld_state_t;

    typedef enum logic [1:0] {
        RC_HOLD,
        RC_FLUSH,
        RC_LOAD,
        RC_NORMAL
    } resp_ctrl_t;

    // A load session blocks fetches, then flush beats stall.
    function automatic resp_ctrl_t resp_ctrl(input logic busy, input logic flush, input logic stall);
        if (busy)       return RC_LOAD;
        else if (flush) return RC_FLUSH;
        else if (stall) return RC_HOLD;
        else            return RC_NORMAL;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-serial loader: two address bytes, then {hi, lo} data pairs written to
// consecutive words until ld_end arrives between words.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_start,
    input  logic                  ld_v,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_end,
    output logic                  we,
    output logic [DEPTH_LOG2-1:0] waddr,
    output logic [15:0]           wdata,
    output logic                  busy
);

    ld_state_t             state, state_nx;
    logic [DEPTH_LOG2-1:0] ld_addr;
    logic [7:0]            hold;

    always_ff @(posedge clk) begin
        if (rst) state <= L_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            L_IDLE: if (ld_start) state_nx = L_AHI;
            L_AHI:  if (ld_v)     state_nx = L_ALO;
            L_ALO:  if (ld_v)     state_nx = L_DHI;
            L_DHI: begin
                if (ld_end)    state_nx = L_IDLE;
                else if (ld_v) state_nx = L_DLO;
            end
            L_DLO:  if (ld_v)     state_nx = L_DHI;
            default:              state_nx = L_IDLE;
        endcase
    end

    // Reset suppresses a write that would coincide with it.
    always_comb begin
        we    = (state == L_DLO) && ld_v && !rst;
        busy  = (state != L_IDLE);
        waddr = ld_addr;
        wdata = {hold, ld_byte};
    end

    // hold carries the high address byte first, then each high data byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
        end else if (ld_v) begin
            unique case (state)
                L_AHI: hold <= ld_byte;
                L_ALO: ld_addr <= DEPTH_LOG2'({hold, ld_byte});
                L_DHI: if (!ld_end) hold <= ld_byte;
                L_DLO: ld_addr <= ld_addr + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_server.sv
// Fetch responder: one-cycle registered read with stall/flush handling and an
// embedded byte-serial loader that owns the memory while a session is active.
module imem_server
    import imem_pkg::*;
#(
    parameter int                INST_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter int                DEPTH_LOG2 = 8,
    parameter logic [INST_W-1:0] NOP_INST   = INST_W'(DEF_NOP_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              v_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] origaddr_o,
    output logic              oor_o,
    input  logic              ld_start_i,
    input  logic              ld_v_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_end_i,
    output logic              ld_busy_o
);

    logic [INST_W-1:0]     mem [0:(1<<DEPTH_LOG2)-1];
    logic                  we;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [15:0]           wdata;
    logic                  oor;
    logic [DEPTH_LOG2-1:0] idx;
    resp_ctrl_t            ctrl;

    imem_loader #(.DEPTH_LOG2(DEPTH_LOG2)) u_loader (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start_i),
        .ld_v     (ld_v_i),
        .ld_byte  (ld_byte_i),
        .ld_end   (ld_end_i),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (ld_busy_o)
    );

    // Memory is deliberately not reset so loaded code survives a core reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= INST_W'(wdata);
    end

    always_comb begin
        oor  = |addr_i[ADDR_W-1:DEPTH_LOG2];
        idx  = addr_i[DEPTH_LOG2-1:0];
        ctrl = resp_ctrl(ld_busy_o, flush_i, stall_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_o        <= 1'b0;
            inst_o     <= NOP_INST;
            origaddr_o <= '0;
            oor_o      <= 1'b0;
        end else begin
            unique case (ctrl)
                RC_LOAD, RC_FLUSH: v_o <= 1'b0;
                RC_HOLD: ;
                RC_NORMAL: begin
                    v_o <= v_i;
                    if (v_i) begin
                        inst_o     <= oor ? NOP_INST : mem[idx];
                        origaddr_o <= addr_i;
                        oor_o      <= oor;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_server.sv
// Randomized scoreboard bench for imem_server: a word-level memory model
// predicts every valid response; a monitor pops and compares on v_o.
module tb_imem_server;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic [15:0] addr_i = '0;
    logic        ld_start_i = 1'b0, ld_v_i = 1'b0, ld_end_i = 1'b0;
    logic [7:0]  ld_byte_i = '0;
    logic        v_o, oor_o, ld_busy_o;
    logic [15:0] inst_o, origaddr_o;

    always #5 clk = ~clk;

    imem_server dut (
        .clk        (clk),
        .rst        (rst),
        .v_i        (v_i),
        .addr_i     (addr_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .v_o        (v_o),
        .inst_o     (inst_o),
        .origaddr_o (origaddr_o),
        .oor_o      (oor_o),
        .ld_start_i (ld_start_i),
        .ld_v_i     (ld_v_i),
        .ld_byte_i  (ld_byte_i),
        .ld_end_i   (ld_end_i),
        .ld_busy_o  (ld_busy_o)
    );

    typedef struct {
        logic [15:0] inst;
        logic [15:0] addr;
        logic        oor;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [15:0] mem_m [256];
    logic [15:0] ld_words[$];
    bit          busy_m;
    bit          last_v;
    rsp_t        last;
    bit          gaps_on;
    bit          f_v, f_st, f_fl;
    logic [15:0] f_a;
    int          n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented response must match the oldest prediction.
    rsp_t e;
    always @(negedge clk) begin
        if (!rst && v_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_v_o", {31'b0, v_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("inst_o", inst_o, e.inst);
                check("origaddr_o", origaddr_o, e.addr);
                check("oor_o", oor_o, e.oor);
            end
        end
    end

    task automatic rand_fetch();
        f_v  = $urandom_range(0, 3) != 0;
        f_a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
        f_st = $urandom_range(0, 4) == 0;
        f_fl = $urandom_range(0, 7) == 0;
    endtask

    task automatic set_fetch(input bit v, input logic [15:0] a, input bit st, input bit fl);
        f_v = v; f_a = a; f_st = st; f_fl = fl;
    endtask

    // One clock: drive everything, predict the response, advance, check busy.
    task automatic step(input bit lst, input bit lv, input logic [7:0] lb, input bit le, input bit busy_next);
        v_i = f_v; addr_i = f_a; stall_i = f_st; flush_i = f_fl;
        ld_start_i = lst; ld_v_i = lv; ld_byte_i = lb; ld_end_i = le;
        if (busy_m || f_fl) begin
            last_v = 1'b0;
        end else if (!f_st) begin
            last_v = f_v;
            if (f_v) begin
                last.oor  = f_a[15:8] != 8'h00;
                last.inst = last.oor ? 16'h0000 : mem_m[f_a[7:0]];
                last.addr = f_a;
            end
        end
        if (last_v) exp_q.push_back(last);
        busy_m = busy_next;
        @(posedge clk); #1;
        check("ld_busy_o", {31'b0, ld_busy_o}, {31'b0, busy_m});
    endtask

    task automatic fetch(input logic [15:0] a, input bit st, input bit fl);
        set_fetch(1'b1, a, st, fl);
        step(1'b0, 1'b0, 8'h00, 1'b0, busy_m);
    endtask

    task automatic gap(input bit allow_end);
        int n = gaps_on ? $urandom_range(0, 2) : 0;
        repeat (n) begin
            rand_fetch();
            step($urandom_range(0, 3) == 0, 1'b0, 8'($urandom),
                 allow_end && ($urandom_range(0, 2) == 0), 1'b1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit allow_end);
        gap(allow_end);
        rand_fetch();
        step(1'b0, 1'b1, b, 1'b0, 1'b1);
    endtask

    // Load ld_words starting at address a; the model memory is updated per word.
    task automatic load(input logic [15:0] a);
        rand_fetch();
        step(1'b1, $urandom_range(0, 1) == 1, 8'($urandom), 1'b0, 1'b1);
        send_byte(a[15:8], 1'b1);
        send_byte(a[7:0], 1'b1);
        for (int i = 0; i < ld_words.size(); i++) begin
            send_byte(ld_words[i][15:8], 1'b0);
            mem_m[8'(a[7:0] + i)] = ld_words[i];
            send_byte(ld_words[i][7:0], 1'b1);
        end
        gap(1'b0);
        rand_fetch();
        step(1'b0, $urandom_range(0, 1) == 1, 8'($urandom), 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rand_fetch();
        v_i = f_v; addr_i = f_a; stall_i = f_st; flush_i = f_fl;
        ld_start_i = 1'b0; ld_v_i = 1'b0; ld_end_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        busy_m = 1'b0;
        last_v = 1'b0;
        last   = '{16'h0000, 16'h0000, 1'b0};
    endtask

    initial begin
        busy_m = 1'b0; last_v = 1'b0; gaps_on = 1'b0;
        last = '{16'h0000, 16'h0000, 1'b0};
        set_fetch(1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_v_o", {31'b0, v_o}, 32'd0);
        check("rst_inst_o", inst_o, 32'h0000);
        check("rst_origaddr_o", origaddr_o, 32'h0000);
        check("rst_oor_o", {31'b0, oor_o}, 32'd0);
        check("rst_ld_busy_o", {31'b0, ld_busy_o}, 32'd0);

        // Fill every word so later random fetches have a defined model value.
        ld_words.delete();
        for (int i = 0; i < 256; i++) ld_words.push_back(16'($urandom));
        load(16'h0000);

        ld_words.delete();
        ld_words.push_back(16'h1234);
        ld_words.push_back(16'hABCD);
        load(16'h0000);
        fetch(16'h0000, 1'b0, 1'b0);
        check("tp_fetch0_v", {31'b0, v_o}, 32'd1);
        check("tp_fetch0_inst", inst_o, 32'h1234);
        fetch(16'h0001, 1'b0, 1'b0);
        check("tp_fetch1_inst", inst_o, 32'hABCD);
        check("tp_fetch1_addr", origaddr_o, 32'h0001);

        fetch(16'h0100, 1'b0, 1'b0);
        check("tp_oor_inst", inst_o, 32'h0000);
        check("tp_oor_flag", {31'b0, oor_o}, 32'd1);
        check("tp_oor_addr", origaddr_o, 32'h0100);

        fetch(16'h0000, 1'b0, 1'b0);
        fetch(16'h0001, 1'b1, 1'b0);
        check("tp_stall_hold_inst", inst_o, 32'h1234);
        check("tp_stall_hold_v", {31'b0, v_o}, 32'd1);
        fetch(16'h0001, 1'b0, 1'b0);
        check("tp_stall_reissue", inst_o, 32'hABCD);

        fetch(16'h0001, 1'b1, 1'b1);
        check("tp_flush_v", {31'b0, v_o}, 32'd0);
        fetch(16'h0000, 1'b0, 1'b0);
        check("tp_after_flush", inst_o, 32'h1234);

        ld_words.delete();
        ld_words.push_back(16'h5A5A);
        ld_words.push_back(16'hC3C3);
        load(16'h00FF);
        fetch(16'h00FF, 1'b0, 1'b0);
        check("tp_wrap_ff", inst_o, 32'h5A5A);
        fetch(16'h0000, 1'b0, 1'b0);
        check("tp_wrap_00", inst_o, 32'hC3C3);

        // Reset after a single high data byte: word 5 must stay intact.
        rand_fetch();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hEE, 1'b0);
        do_reset();
        check("tp_rst_busy", {31'b0, ld_busy_o}, 32'd0);
        check("tp_rst_v_o", {31'b0, v_o}, 32'd0);
        fetch(16'h0005, 1'b0, 1'b0);
        fetch(16'h0000, 1'b0, 1'b0);
        check("tp_rst_keep_old", inst_o, 32'hC3C3);

        gaps_on = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                ld_words.delete();
                for (int i = 0; i < $urandom_range(1, 4); i++) ld_words.push_back(16'($urandom));
                load(16'($urandom));
            end else begin
                rand_fetch();
                step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            end
        end

        set_fetch(1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_server.md
# imem_server

Instruction-memory responder for the core's fetch interface: accepts the IF-stage fetch address and returns the instruction word plus its original address to ID one cycle later. It honours ID stall and branch flush. It also contains a byte-serial loader that fills the memory before or between runs. It sits between `ifetch` (address side) and `idecode` (instruction side), replacing the behavioural instruction ROM.

## Interface
- `INST_W`, 16, instruction width
- `ADDR_W`, 16, fetch address width
- `DEPTH_LOG2`, 8, log2 of memory depth in words
- `NOP_INST`, 16'h0000, word returned for out-of-range fetches

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `v_i`  in  1  fetch request valid (from IF).
- `addr_i`  in  ADDR_W  fetch word address.
- `stall_i`  in  1  ID cannot accept; hold outputs.
- `flush_i`  in  1  branch taken; discard the response due next cycle.
- `v_o`  out  1  response valid (to ID).
- `inst_o`  out  INST_W  instruction word.
- `origaddr_o`  out  ADDR_W  address the word was fetched from.
- `oor_o`  out  1  response came from an out-of-range address.
- `ld_start_i`  in  1  begin a load session.
- `ld_v_i`  in  1  loader byte valid.
- `ld_byte_i`  in  8  loader byte.
- `ld_end_i`  in  1  end session; sampled only in `L_DHI`.
- `ld_busy_o`  out  1  load session active.

## Operation
- Memory: 2^DEPTH_LOG2 words of INST_W bits. Word index is `addr_i[DEPTH_LOG2-1:0]`.
- Out of range: any nonzero `addr_i[ADDR_W-1:DEPTH_LOG2]`. Response is `inst_o`=NOP_INST with `oor_o`=1.
- Priority per cycle: rst > ld_busy > flush_i > stall_i > normal.
- Normal: `v_i`=1 registers the response, so `v_o`=1, `inst_o`=mem[idx], `origaddr_o`=addr_i next cycle. `v_i`=0 gives `v_o`=0 next cycle.
- `stall_i`=1: `v_o`, `inst_o`, `origaddr_o`, `oor_o` all hold. The request is ignored; IF re-presents it.
- `flush_i`=1: `v_o`=0 next cycle regardless of `v_i` and `stall_i`.
- While `ld_busy_o`=1: `v_o`=0 and fetches are ignored. Read/write collisions therefore cannot occur.
- Loader FSM states and transitions:
  - `L_IDLE`: on `ld_start_i` go to `L_AHI`.
  - `L_AHI`: on a valid byte, load address[15:8] and go to `L_ALO`.
  - `L_ALO`: on a valid byte, load address[7:0] and go to `L_DHI`.
  - `L_DHI`: if `ld_end_i`, go to `L_IDLE`. Otherwise, on a valid byte, capture data[15:8] and go to `L_DLO`.
  - `L_DLO`: on a valid byte, write mem[ld_addr] = {hi, byte}, increment ld_addr, and go to `L_DHI`.
  - Bytes with `ld_v_i`=0 are ignored in every state.
- Address arithmetic: ld_addr is DEPTH_LOG2 bits; upper address bits are dropped. The increment wraps from 2^DEPTH_LOG2-1 to 0.
- `ld_start_i` outside `L_IDLE` is ignored. `ld_end_i` outside `L_DHI` is ignored, so a half word is never written.
- `ld_busy_o` = (state != `L_IDLE`).

## Timing
- Fetch latency is exactly 1 cycle: request at edge n gives valid data after edge n+1.
- Throughput is one fetch per cycle with no bubbles when unstalled.
- Reset values: `v_o`=0, `inst_o`=NOP_INST, `origaddr_o`=0, `oor_o`=0, `ld_busy_o`=0, FSM in `L_IDLE`. Memory contents are unchanged by reset.
- Reset mid-load: the FSM returns to `L_IDLE`. Completed words remain written; a captured high byte is discarded.
- The first fetch is accepted in the cycle the FSM returns to `L_IDLE`, because `ld_busy_o` is registered.
- Simultaneous `flush_i` and `stall_i`: flush wins and `v_o`=0.
- Write in `L_DLO` takes effect at that edge. A later read sees the new data.

## Structure
- Package `imem_pkg` holds:
  - the loader state enum (`L_IDLE`, `L_AHI`, `L_ALO`, `L_DHI`, `L_DLO`);
  - a shared `NOP_INST` default;
  - a 2-bit response-control code (HOLD/FLUSH/LOAD/NORMAL) used by the priority mux.
- Sub-module `imem_loader`: the FSM, address counter and byte assembly. Outputs are `we`, `waddr`, `wdata`, `busy`.
- Top level contains the memory array, the out-of-range check and the response register.

## Test plan
- Load words 0x1234 at 0x0000 and 0xABCD at 0x0001 (bytes 00 00 12 34 AB CD, then end), then fetch 0, 1 in back-to-back cycles → `v_o`=1 with 1234/0000 then ABCD/0001.
- Fetch 0x0100 (out of range) → `inst_o`=0000, `oor_o`=1, `origaddr_o`=0100.
- Fetch 0, 1 with `stall_i`=1 in the cycle of fetch 1 → the 1234/0000 response is held for two cycles. Fetch 1 is re-issued and answered on the following cycle.
- `flush_i` with `v_i`=1 → `v_o`=0 next cycle. The next unflushed fetch returns normally.
- Load starting at 0x00FF with two words → the second is written to 0x0000. `ld_busy_o`=1 throughout, and concurrent fetches give `v_o`=0.
- `rst` after a single DHI byte → FSM idle, `ld_busy_o`=0, target word unchanged, and earlier loaded words are still readable.
